// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a combinational-read, edge-write data memory.
// Byte stores are read-modify-write so the neighbouring byte of the 16-bit word is preserved.
module mem_access_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] load_data,
  output logic        readEnable,
  output logic        writeEnable,
  output logic [15:0] address,
  output logic [15:0] writeData,
  input  logic [15:0] readData
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        byte_q, signed_q, err_q;
  logic [15:0] addr_q, wdata_q, load_q;
  logic [7:0]  merge_q;
  logic        accept, reject;

  // Handshake: a request is taken on any rising edge where ready=1 and req_valid=1;
  // req_* are sampled only at that edge and ignored at all other times (no queuing).
  assign accept = (state_q == IDLE) && req_valid;
  // A word at the top byte address would span past the end of memory.
  assign reject = !req_byte && (req_addr == 16'hFFFF);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reject)          state_d = DONE;
          else if (!req_write) state_d = RD;
          else if (req_byte)   state_d = RMW_RD;
          else                 state_d = WR;
        end
      end
      RD:      state_d = DONE;
      RMW_RD:  state_d = WR;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      load_q   <= 16'h0000;
      merge_q  <= 8'h00;
    end else begin
      if (accept) begin
        byte_q   <= req_byte;
        signed_q <= req_signed;
        err_q    <= reject;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == RD) begin
        if (byte_q) load_q <= {{8{readData[7] & signed_q}}, readData[7:0]};
        else        load_q <= readData;
      end
      if (state_q == RMW_RD) merge_q <= readData[15:8];
    end
  end

  // Memory-port outputs decode from state and latched fields only, never from req_*.
  always_comb begin
    ready       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    readEnable  = 1'b0;
    writeEnable = 1'b0;
    address     = 16'h0000;
    writeData   = 16'h0000;
    case (state_q)
      IDLE: ready = 1'b1;
      RD, RMW_RD: begin
        readEnable = 1'b1;
        address    = addr_q;
      end
      WR: begin
        writeEnable = 1'b1;
        address     = addr_q;
        writeData   = byte_q ? {merge_q, wdata_q[7:0]} : wdata_q;
      end
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ready = 1'b0;
    endcase
  end

  assign busy      = ~ready;
  assign load_data = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory, byte-level reference model, directed
// cases with literal expectations, then randomized loads/stores and a mid-operation reset.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic        ready, busy, done, err, readEnable, writeEnable;
  logic [15:0] load_data, address, writeData, readData;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] model_ld = 16'h0;
  logic        pre_en = 1'b0;
  logic [15:0] pre_a = 16'h0;
  logic [7:0]  pre_d = 8'h0;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .readEnable(readEnable), .writeEnable(writeEnable),
    .address(address), .writeData(writeData), .readData(readData)
  );

  always #5 clock = ~clock;

  // Data memory: combinational read, write at the clock edge.
  assign readData = {mem[address + 16'd1], mem[address]};
  always @(posedge clock) begin
    if (writeEnable) begin
      mem[address]         <= writeData[7:0];
      mem[address + 16'd1] <= writeData[15:8];
    end else if (pre_en) begin
      mem[pre_a] <= pre_d;
    end
  end

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle output invariants.
  always @(negedge clock) begin
    check16("busy_is_not_ready", {15'd0, busy}, {15'd0, ~ready});
    check16("no_dual_enable", {15'd0, readEnable & writeEnable}, 16'd0);
    if (!readEnable && !writeEnable) check16("address_zero_idle", address, 16'h0);
    if (!writeEnable) check16("wdata_zero_idle", writeData, 16'h0);
    if (err) check16("err_only_with_done", {15'd0, done}, 16'd1);
    if (ready) check16("idle_no_enables", {14'd0, readEnable, writeEnable}, 16'd0);
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    ref_mem[a] = d;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic b, input logic s, input logic [15:0] a,
                        input logic [15:0] wd, input bit hold, output logic [15:0] ld);
    logic        e;
    int          lat, cyc, re_n, we_n, re_exp, we_exp;
    logic [15:0] exp_wd;
    bit          got;
    check16("ready_before_req", {15'd0, ready}, 16'd1);
    check16("load_data_held", load_data, model_ld);
    e      = !b && (a == 16'hFFFF);
    lat    = e ? 1 : ((w && b) ? 3 : 2);
    re_exp = e ? 0 : ((!w || b) ? 1 : 0);
    we_exp = (w && !e) ? 1 : 0;
    exp_wd = b ? {ref_mem[a + 16'd1], wd[7:0]} : wd;
    if (!e) begin
      if (!w) begin
        if (b) model_ld = {{8{s & ref_mem[a][7]}}, ref_mem[a]};
        else   model_ld = {ref_mem[a + 16'd1], ref_mem[a]};
      end else begin
        ref_mem[a] = wd[7:0];
        if (!b) ref_mem[a + 16'd1] = wd[15:8];
      end
    end
    req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
    req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    if (!hold) req_valid = 1'b0;
    // Fields change after acceptance; the unit must use the latched copy.
    req_write = 1'($urandom); req_byte = 1'($urandom); req_signed = 1'($urandom);
    req_addr = 16'($urandom); req_wdata = 16'($urandom);
    cyc = 0; got = 1'b0; re_n = 0; we_n = 0;
    while (!got && cyc < 12) begin
      @(negedge clock);
      cyc++;
      if (readEnable) re_n++;
      if (writeEnable) begin
        we_n++;
        check16("write_data", writeData, exp_wd);
      end
      if (readEnable || writeEnable) check16("mem_address", address, a);
      if (done) got = 1'b1;
    end
    req_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles for addr %h", cyc, a);
    end
    check16("latency", 16'(cyc), 16'(lat));
    check16("err_flag", {15'd0, err}, {15'd0, e});
    check16("read_enable_cycles", 16'(re_n), 16'(re_exp));
    check16("write_enable_cycles", 16'(we_n), 16'(we_exp));
    check16("load_data", load_data, model_ld);
    ld = load_data;
    @(negedge clock);
  endtask

  task automatic compare_mem();
    for (int i = 0; i < 32; i++)
      check16("mem_byte", {8'd0, mem[16'(i)]}, {8'd0, ref_mem[16'(i)]});
    check16("mem_byte_fffe", {8'd0, mem[16'hFFFE]}, {8'd0, ref_mem[16'hFFFE]});
    check16("mem_byte_ffff", {8'd0, mem[16'hFFFF]}, {8'd0, ref_mem[16'hFFFF]});
  endtask

  initial begin
    logic [15:0] ld, a;
    int          we_seen, done_seen;
    #1 reset = 1'b0;
    @(negedge clock);
    preload(16'h0000, 8'h99);
    preload(16'h0001, 8'hAB);
    for (int i = 2; i < 32; i++) preload(16'(i), 8'($urandom));
    preload(16'hFFFE, 8'($urandom));
    preload(16'hFFFF, 8'($urandom));
    @(negedge clock);
    check16("reset_ready", {15'd0, ready}, 16'd1);
    check16("reset_busy_done_err", {13'd0, busy, done, err}, 16'd0);
    check16("reset_load_data", load_data, 16'h0);
    check16("reset_enables", {14'd0, readEnable, writeEnable}, 16'd0);
    check16("reset_address", address, 16'h0);
    check16("reset_write_data", writeData, 16'h0);

    // Request offered on the very first edge after reset release.
    reset = 1'b1;
    do_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, ld);
    check16("lit_word_load", ld, 16'hAB99);
    do_req(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0, 1'b0, ld);
    check16("lit_byte_load_signed", ld, 16'hFFAB);
    do_req(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, ld);
    check16("lit_byte_load_unsigned", ld, 16'h00AB);
    do_req(1'b1, 1'b1, 1'b0, 16'h0000, 16'h005A, 1'b0, ld);
    check16("lit_byte_store_mem", {mem[16'h0001], mem[16'h0000]}, 16'hAB5A);
    do_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, ld);
    check16("lit_load_after_byte_store", ld, 16'hAB5A);
    do_req(1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 1'b1, ld);
    check16("lit_word_store_mem", {mem[16'h0003], mem[16'h0002]}, 16'h1234);
    do_req(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0, 1'b0, ld);
    check16("lit_err_load_unchanged", ld, 16'hAB5A);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 16'hFFFF;
        1:       a = 16'hFFFE;
        default: a = 16'($urandom_range(0, 30));
      endcase
      do_req(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom),
             1'($urandom), ld);
    end
    compare_mem();

    // Reset while the byte store is in its read phase.
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0004; req_wdata = 16'h00C3;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check16("rmw_read_phase", {15'd0, readEnable}, 16'd1);
    reset = 1'b0;
    #1;
    model_ld = 16'h0;
    check16("abort_ready", {15'd0, ready}, 16'd1);
    check16("abort_busy_done_err", {13'd0, busy, done, err}, 16'd0);
    check16("abort_load_data", load_data, 16'h0);
    check16("abort_enables", {14'd0, readEnable, writeEnable}, 16'd0);
    check16("abort_address_wdata", address | writeData, 16'h0);
    we_seen = 0; done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (writeEnable) we_seen++;
      if (done) done_seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (writeEnable) we_seen++;
      if (done) done_seen++;
    end
    check16("abort_no_write", 16'(we_seen), 16'd0);
    check16("abort_no_done", 16'(done_seen), 16'd0);
    compare_mem();
    do_req(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, 1'b0, ld);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
